// File: rtl/i2c_reg_sequencer.sv
// i2c_reg_sequencer
//   Turns one host register-access command into the byte-op sequence of the
//   downstream I2C byte engine:
//     write: START, DEV+W, REG, DATA x len, STOP
//     read : START, DEV+W, REG, RSTART, DEV+R, DATA x len (NACK last), STOP
//   A zero-length command of either direction runs START, DEV+W, REG, STOP.
//   Every byte op runs ISSUE -> WAIT_HI -> WAIT_LO.
//
// Ports
//   clk, rst_n                      clock, asynchronous active-low reset
//   cmd_valid/cmd_ready             command handshake (ready only when idle)
//   cmd_rw/dev_addr/reg_addr/len    command fields (1 = read)
//   wr_data/wr_valid/wr_ready       write byte stream (ready pulses on consume)
//   rd_data/rd_valid                read byte stream (one pulse per byte)
//   done, err                       end-of-transaction pulse, sticky timeout
//   eng_start/request/data/read_ack byte engine op strobe and operands
//   eng_busy, eng_rdata             byte engine status and read result
module i2c_reg_sequencer #(
  parameter int LEN_W        = 4,
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_rw,
  input  logic [6:0]       cmd_dev_addr,
  input  logic [7:0]       cmd_reg_addr,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic [7:0]       wr_data,
  input  logic             wr_valid,
  output logic             wr_ready,
  output logic [7:0]       rd_data,
  output logic             rd_valid,
  output logic             done,
  output logic             err,
  output logic             eng_start,
  output logic [1:0]       eng_request,
  output logic [7:0]       eng_data,
  output logic             eng_read_ack,
  input  logic             eng_busy,
  input  logic [7:0]       eng_rdata
);

  localparam logic [3:0] P_IDLE   = 4'd0;
  localparam logic [3:0] P_START  = 4'd1;
  localparam logic [3:0] P_DEVW   = 4'd2;
  localparam logic [3:0] P_REG    = 4'd3;
  localparam logic [3:0] P_WDATA  = 4'd4;
  localparam logic [3:0] P_RSTART = 4'd5;
  localparam logic [3:0] P_DEVR   = 4'd6;
  localparam logic [3:0] P_RDATA  = 4'd7;
  localparam logic [3:0] P_STOP   = 4'd8;
  localparam logic [3:0] P_DONE   = 4'd9;

  localparam logic [1:0] S_ISSUE   = 2'd0;
  localparam logic [1:0] S_WAIT_HI = 2'd1;
  localparam logic [1:0] S_WAIT_LO = 2'd2;

  localparam logic [1:0] OP_START = 2'd0;
  localparam logic [1:0] OP_STOP  = 2'd1;
  localparam logic [1:0] OP_READ  = 2'd2;
  localparam logic [1:0] OP_WRITE = 2'd3;

  localparam int              TW          = $clog2(BUSY_TIMEOUT + 1) + 1;
  localparam logic [TW-1:0]   TIMEOUT_LIM = TW'(BUSY_TIMEOUT);

  logic [3:0]       phase_r;
  logic [1:0]       step_r;
  logic             rw_r;
  logic [6:0]       dev_r;
  logic [7:0]       reg_r;
  logic [LEN_W-1:0] len_r;
  logic [LEN_W-1:0] count_r;
  logic [TW-1:0]    timer_r;

  logic [LEN_W-1:0] count_inc_s;
  logic [3:0]       phase_after_s;
  logic [1:0]       req_s;
  logic [7:0]       data_s;
  logic             ack_s;

  // Phase that follows the current byte op once the engine has finished it.
  always_comb begin
    count_inc_s   = count_r + LEN_W'(1);
    phase_after_s = P_IDLE;
    case (phase_r)
      P_START:  phase_after_s = P_DEVW;
      P_DEVW:   phase_after_s = P_REG;
      P_REG: begin
        if (len_r == {LEN_W{1'b0}}) begin
          phase_after_s = P_STOP;
        end else if (rw_r) begin
          phase_after_s = P_RSTART;
        end else begin
          phase_after_s = P_WDATA;
        end
      end
      P_WDATA:  phase_after_s = (count_inc_s == len_r) ? P_STOP : P_WDATA;
      P_RSTART: phase_after_s = P_DEVR;
      P_DEVR:   phase_after_s = P_RDATA;
      P_RDATA:  phase_after_s = (count_inc_s == len_r) ? P_STOP : P_RDATA;
      P_STOP:   phase_after_s = P_DONE;
      default:  phase_after_s = P_IDLE;
    endcase
  end

  // Engine opcode and operands for the phase about to be issued.
  always_comb begin
    req_s  = OP_START;
    data_s = 8'h00;
    ack_s  = 1'b0;
    case (phase_r)
      P_START, P_RSTART: req_s = OP_START;
      P_DEVW: begin
        req_s  = OP_WRITE;
        data_s = {dev_r, 1'b0};
      end
      P_REG: begin
        req_s  = OP_WRITE;
        data_s = reg_r;
      end
      P_WDATA: begin
        req_s  = OP_WRITE;
        data_s = wr_data;
      end
      P_DEVR: begin
        req_s  = OP_WRITE;
        data_s = {dev_r, 1'b1};
      end
      P_RDATA: begin
        req_s = OP_READ;
        // The last byte of a read burst is NACKed to end the slave's transmit.
        ack_s = (count_r != (len_r - LEN_W'(1)));
      end
      P_STOP:  req_s = OP_STOP;
      default: req_s = OP_START;
    endcase
  end

  // Sequencer state, counters and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_r      <= P_IDLE;
      step_r       <= S_ISSUE;
      rw_r         <= 1'b0;
      dev_r        <= 7'h00;
      reg_r        <= 8'h00;
      len_r        <= {LEN_W{1'b0}};
      count_r      <= {LEN_W{1'b0}};
      timer_r      <= {TW{1'b0}};
      cmd_ready    <= 1'b1;
      wr_ready     <= 1'b0;
      rd_data      <= 8'h00;
      rd_valid     <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      eng_start    <= 1'b0;
      eng_request  <= 2'd0;
      eng_data     <= 8'h00;
      eng_read_ack <= 1'b0;
    end else begin
      eng_start <= 1'b0;
      wr_ready  <= 1'b0;
      rd_valid  <= 1'b0;
      done      <= 1'b0;
      case (phase_r)
        P_IDLE: begin
          if (cmd_valid) begin
            rw_r      <= cmd_rw;
            dev_r     <= cmd_dev_addr;
            reg_r     <= cmd_reg_addr;
            len_r     <= cmd_len;
            count_r   <= {LEN_W{1'b0}};
            err       <= 1'b0;
            cmd_ready <= 1'b0;
            phase_r   <= P_START;
            step_r    <= S_ISSUE;
          end else begin
            cmd_ready <= 1'b1;
          end
        end
        P_DONE: begin
          done      <= 1'b1;
          cmd_ready <= 1'b1;
          phase_r   <= P_IDLE;
          step_r    <= S_ISSUE;
        end
        default: begin
          case (step_r)
            S_ISSUE: begin
              // Write data stalls here until the host offers a byte.
              if ((phase_r != P_WDATA) || wr_valid) begin
                eng_start    <= 1'b1;
                eng_request  <= req_s;
                eng_data     <= data_s;
                eng_read_ack <= ack_s;
                wr_ready     <= (phase_r == P_WDATA);
                timer_r      <= {TW{1'b0}};
                step_r       <= S_WAIT_HI;
              end else begin
                step_r <= S_ISSUE;
              end
            end
            S_WAIT_HI: begin
              if (eng_busy) begin
                step_r <= S_WAIT_LO;
              end else if (timer_r == TIMEOUT_LIM) begin
                // Engine never acknowledged the op: abandon without STOP.
                err     <= 1'b1;
                phase_r <= P_DONE;
                step_r  <= S_ISSUE;
              end else begin
                timer_r <= timer_r + TW'(1);
              end
            end
            S_WAIT_LO: begin
              if (!eng_busy) begin
                if (phase_r == P_RDATA) begin
                  rd_data  <= eng_rdata;
                  rd_valid <= 1'b1;
                end else begin
                  rd_valid <= 1'b0;
                end
                if ((phase_r == P_WDATA) || (phase_r == P_RDATA)) begin
                  count_r <= count_inc_s;
                end else begin
                  count_r <= count_r;
                end
                phase_r <= phase_after_s;
                step_r  <= S_ISSUE;
              end else begin
                step_r <= S_WAIT_LO;
              end
            end
            default: step_r <= S_ISSUE;
          endcase
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_reg_sequencer.sv
// Self-checking bench for i2c_reg_sequencer: an engine responder, a
// transaction-level expectation model (queue of byte ops and read bytes)
// checked every cycle, and literal expectations for the directed cases.
module tb_i2c_reg_sequencer;

  localparam int LEN_W = 4;
  localparam int BT    = 16;

  typedef struct packed {
    logic [1:0] req;
    logic [7:0] data;
    logic       ack;
    logic       wdata;
  } op_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic             cmd_rw = 1'b0;
  logic [6:0]       cmd_dev_addr = 7'h00;
  logic [7:0]       cmd_reg_addr = 8'h00;
  logic [LEN_W-1:0] cmd_len = 4'd0;
  logic [7:0]       wr_data = 8'h00;
  logic             wr_valid = 1'b0;
  logic             wr_ready;
  logic [7:0]       rd_data;
  logic             rd_valid;
  logic             done;
  logic             err;
  logic             eng_start;
  logic [1:0]       eng_request;
  logic [7:0]       eng_data;
  logic             eng_read_ack;
  logic             eng_busy = 1'b0;
  logic [7:0]       eng_rdata = 8'h00;

  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   last_start = -100;
  int   start_cyc = 0;
  int   done_cyc = 0;
  int   wr_cnt = 0;
  int   done_cnt = 0;
  int   rise_dly = 1;
  int   busy_len = 2;
  bit   never_busy = 1'b0;
  logic exp_err = 1'b0;
  logic [7:0] last_data = 8'h00;
  logic       last_ack = 1'b0;

  op_t        exp_q[$];
  op_t        slog[$];
  logic [7:0] rd_q[$];
  logic [7:0] eng_rq[$];
  logic [7:0] wq[$];
  logic [7:0] rlog[$];

  i2c_reg_sequencer #(.LEN_W(LEN_W), .BUSY_TIMEOUT(BT)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
    .cmd_dev_addr(cmd_dev_addr), .cmd_reg_addr(cmd_reg_addr), .cmd_len(cmd_len),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .done(done), .err(err),
    .eng_start(eng_start), .eng_request(eng_request), .eng_data(eng_data),
    .eng_read_ack(eng_read_ack), .eng_busy(eng_busy), .eng_rdata(eng_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Byte engine: busy rises rise_dly cycles after a strobe, lasts busy_len cycles.
  initial begin : engine
    int pend;
    int left;
    bit pend_read;
    pend = 0;
    left = 0;
    pend_read = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        eng_busy = 1'b0;
        pend = 0;
        left = 0;
      end else begin
        if (eng_busy) begin
          left--;
          if (left == 0) begin
            eng_busy = 1'b0;
            if (pend_read && eng_rq.size() > 0) eng_rdata = eng_rq.pop_front();
          end
        end else if (pend > 0) begin
          pend--;
          if (pend == 0) begin
            eng_busy = 1'b1;
            left = busy_len;
          end
        end
        if (eng_start && !never_busy) begin
          pend = rise_dly;
          pend_read = (eng_request == 2'd2);
        end
      end
    end
  end

  // Per-cycle comparison of DUT outputs against the expectation queues.
  initial begin : checker_proc
    op_t op;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n) begin
        cyc++;
        if (eng_start) begin
          check("start_gap", 32'((cyc - last_start) >= 3), 32'd1);
          last_start = cyc;
          start_cyc = cyc;
          slog.push_back(op_t'{eng_request, eng_data, eng_read_ack, wr_ready});
          last_data = eng_data;
          last_ack = eng_read_ack;
          if (exp_q.size() == 0) begin
            check("unexpected_start", 32'(eng_start), 32'd0);
          end else begin
            op = exp_q.pop_front();
            check("eng_request", 32'(eng_request), 32'(op.req));
            if (op.req == 2'd3) check("eng_data", 32'(eng_data), 32'(op.data));
            if (op.req == 2'd2) check("eng_read_ack", 32'(eng_read_ack), 32'(op.ack));
            check("wr_ready_with_start", 32'(wr_ready), 32'(op.wdata));
          end
        end else begin
          check("wr_ready_without_start", 32'(wr_ready), 32'd0);
        end
        if (eng_busy) begin
          check("eng_data_held", 32'(eng_data), 32'(last_data));
          check("read_ack_held", 32'(eng_read_ack), 32'(last_ack));
        end
        if (eng_start || eng_busy) check("cmd_ready_in_txn", 32'(cmd_ready), 32'd0);
        if (rd_valid) begin
          rlog.push_back(rd_data);
          if (rd_q.size() == 0) check("unexpected_rd_valid", 32'(rd_valid), 32'd0);
          else check("rd_data", 32'(rd_data), 32'(rd_q.pop_front()));
        end
        if (done) begin
          done_cnt++;
          done_cyc = cyc;
          check("err_at_done", 32'(err), 32'(exp_err));
        end
        if (wr_ready) wr_cnt++;
      end
    end
  end

  task automatic prep(input logic rw, input logic [6:0] dev, input logic [7:0] rg, input int len);
    exp_q.delete();
    slog.delete();
    rlog.delete();
    exp_q.push_back(op_t'{2'd0, 8'h00, 1'b0, 1'b0});
    exp_q.push_back(op_t'{2'd3, {dev, 1'b0}, 1'b0, 1'b0});
    exp_q.push_back(op_t'{2'd3, rg, 1'b0, 1'b0});
    if (len > 0) begin
      if (!rw) begin
        for (int i = 0; i < len; i++) exp_q.push_back(op_t'{2'd3, wq[i], 1'b0, 1'b1});
      end else begin
        exp_q.push_back(op_t'{2'd0, 8'h00, 1'b0, 1'b0});
        exp_q.push_back(op_t'{2'd3, {dev, 1'b1}, 1'b0, 1'b0});
        for (int i = 0; i < len; i++) exp_q.push_back(op_t'{2'd2, 8'h00, (i != len - 1), 1'b0});
      end
    end
    exp_q.push_back(op_t'{2'd1, 8'h00, 1'b0, 1'b0});
  endtask

  task automatic issue(input logic rw, input logic [6:0] dev, input logic [7:0] rg, input int len);
    @(negedge clk);
    check("cmd_ready_idle", 32'(cmd_ready), 32'd1);
    cmd_rw = rw;
    cmd_dev_addr = dev;
    cmd_reg_addr = rg;
    cmd_len = 4'(len);
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("cmd_accepted", 32'(cmd_ready), 32'd0);
    check("err_cleared", 32'(err), 32'd0);
  endtask

  task automatic feed(input int len, input int stall);
    int k;
    for (int i = 0; i < len; i++) begin
      if (i == 0 && stall > 0) begin
        wr_valid = 1'b0;
        repeat (stall) @(negedge clk);
        check("stall_starts", 32'(slog.size()), 32'd3);
        wr_valid = 1'b1;
        wr_data = wq[0];
        @(negedge clk);
        check("resume_start", 32'(eng_start), 32'd1);
        check("resume_wr_ready", 32'(wr_ready), 32'd1);
      end else begin
        wr_valid = 1'b1;
        wr_data = wq[i];
        k = 0;
        do begin
          @(negedge clk);
          k++;
        end while (!wr_ready && k < 300);
        check("wr_ready_seen", 32'(wr_ready), 32'd1);
      end
    end
    wr_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int k;
    k = 0;
    while (done !== 1'b1 && k < 600) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_done_seen"}, 32'(done), 32'd1);
    check({tag, "_ops_left"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_rd_left"}, 32'(rd_q.size()), 32'd0);
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
    check({tag, "_idle"}, 32'(cmd_ready), 32'd1);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int w0;
    int d0;
    int k;
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_eng_start", 32'(eng_start), 32'd0);
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    check("rst_wr_ready", 32'(wr_ready), 32'd0);
    rst_n = 1'b1;

    // 1: write dev 0x50 reg 0x10, data AA BB, slow engine.
    rise_dly = 3;
    busy_len = 4;
    wq.delete();
    wq.push_back(8'hAA);
    wq.push_back(8'hBB);
    prep(1'b0, 7'h50, 8'h10, 2);
    w0 = wr_cnt;
    d0 = done_cnt;
    issue(1'b0, 7'h50, 8'h10, 2);
    feed(2, 0);
    wait_done("t1");
    check("t1_nops", 32'(slog.size()), 32'd6);
    check("t1_req0", 32'(slog[0].req), 32'd0);
    check("t1_devw", 32'(slog[1].data), 32'hA0);
    check("t1_reg", 32'(slog[2].data), 32'h10);
    check("t1_d0", 32'(slog[3].data), 32'hAA);
    check("t1_d1", 32'(slog[4].data), 32'hBB);
    check("t1_stop", 32'(slog[5].req), 32'd1);
    check("t1_wr_ready_cnt", 32'(wr_cnt - w0), 32'd2);
    check("t1_done_cnt", 32'(done_cnt - d0), 32'd1);
    check("t1_err", 32'(err), 32'd0);

    // 2: read dev 0x50 reg 0x20 len 3.
    rise_dly = 1;
    busy_len = 2;
    eng_rq = '{8'h11, 8'h22, 8'h33};
    rd_q = '{8'h11, 8'h22, 8'h33};
    prep(1'b1, 7'h50, 8'h20, 3);
    issue(1'b1, 7'h50, 8'h20, 3);
    wait_done("t2");
    check("t2_nops", 32'(slog.size()), 32'd9);
    check("t2_rstart", 32'(slog[3].req), 32'd0);
    check("t2_devr", 32'(slog[4].data), 32'hA1);
    check("t2_read_req", 32'(slog[5].req), 32'd2);
    check("t2_ack0", 32'(slog[5].ack), 32'd1);
    check("t2_ack1", 32'(slog[6].ack), 32'd1);
    check("t2_ack2", 32'(slog[7].ack), 32'd0);
    check("t2_nrd", 32'(rlog.size()), 32'd3);
    check("t2_rd0", 32'(rlog[0]), 32'h11);
    check("t2_rd2", 32'(rlog[2]), 32'h33);

    // 3: zero-length read, no repeated start.
    prep(1'b1, 7'h3C, 8'h05, 0);
    issue(1'b1, 7'h3C, 8'h05, 0);
    wait_done("t3");
    check("t3_nops", 32'(slog.size()), 32'd4);
    check("t3_devw", 32'(slog[1].data), 32'h78);
    check("t3_reg", 32'(slog[2].data), 32'h05);
    check("t3_stop", 32'(slog[3].req), 32'd1);
    check("t3_nrd", 32'(rlog.size()), 32'd0);

    // 4: write len 1 with the host stalling.
    wq.delete();
    wq.push_back(8'h5A);
    prep(1'b0, 7'h22, 8'h33, 1);
    issue(1'b0, 7'h22, 8'h33, 1);
    feed(1, 45);
    wait_done("t4");
    check("t4_nops", 32'(slog.size()), 32'd5);
    check("t4_data", 32'(slog[3].data), 32'h5A);

    // 5: engine never goes busy, then recovery.
    never_busy = 1'b1;
    exp_q.delete();
    slog.delete();
    exp_q.push_back(op_t'{2'd0, 8'h00, 1'b0, 1'b0});
    exp_err = 1'b1;
    issue(1'b0, 7'h11, 8'h22, 1);
    wait_done("t5");
    check("t5_nops", 32'(slog.size()), 32'd1);
    check("t5_latency_min", 32'((done_cyc - start_cyc) >= BT + 1), 32'd1);
    check("t5_latency_max", 32'((done_cyc - start_cyc) <= BT + 3), 32'd1);
    repeat (5) @(negedge clk);
    check("t5_err_sticky", 32'(err), 32'd1);
    never_busy = 1'b0;
    exp_err = 1'b0;
    wq.delete();
    wq.push_back(8'hC3);
    prep(1'b0, 7'h11, 8'h22, 1);
    issue(1'b0, 7'h11, 8'h22, 1);
    feed(1, 0);
    wait_done("t5b");
    check("t5b_data", 32'(slog[3].data), 32'hC3);
    check("t5b_err", 32'(err), 32'd0);

    // 6: reset in the middle of a read burst.
    eng_rq = '{8'h44, 8'h55, 8'h66};
    rd_q = '{8'h44, 8'h55, 8'h66};
    prep(1'b1, 7'h68, 8'h0F, 3);
    issue(1'b1, 7'h68, 8'h0F, 3);
    k = 0;
    while (rlog.size() < 1 && k < 300) begin
      @(negedge clk);
      k++;
    end
    check("t6_in_rdata", 32'(rlog.size()), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t6_cmd_ready", 32'(cmd_ready), 32'd1);
    check("t6_eng_start", 32'(eng_start), 32'd0);
    check("t6_eng_request", 32'(eng_request), 32'd0);
    check("t6_eng_data", 32'(eng_data), 32'd0);
    check("t6_read_ack", 32'(eng_read_ack), 32'd0);
    check("t6_rd_valid", 32'(rd_valid), 32'd0);
    check("t6_rd_data", 32'(rd_data), 32'd0);
    check("t6_done", 32'(done), 32'd0);
    check("t6_err", 32'(err), 32'd0);
    exp_q.delete();
    rd_q.delete();
    eng_rq.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) begin
      @(negedge clk);
      check("t6_no_rd_valid", 32'(rd_valid), 32'd0);
      check("t6_no_done", 32'(done), 32'd0);
    end
    check("t6_idle", 32'(cmd_ready), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
